// File: rtl/fpnew_pkg.sv
// Shared FP types for the write-back class encoder: formats, operand info,
// encoder modes, FCLASS bit positions and the canonical quiet-NaN helper.
package fpnew_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    localparam int unsigned MAX_WIDTH = 64;

    typedef struct packed {
        logic is_normal;
        logic is_subnormal;
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_signalling;
        logic is_quiet;
        logic is_boxed;
    } fp_info_t;

    typedef enum logic {
        CLASS_MASK = 1'b0,
        CANON_BOX  = 1'b1
    } class_mode_e;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    localparam int unsigned NUM_CLASSES    = 10;
    localparam int unsigned CLASS_NEG_INF  = 0;
    localparam int unsigned CLASS_NEG_NORM = 1;
    localparam int unsigned CLASS_NEG_SUB  = 2;
    localparam int unsigned CLASS_NEG_ZERO = 3;
    localparam int unsigned CLASS_POS_ZERO = 4;
    localparam int unsigned CLASS_POS_SUB  = 5;
    localparam int unsigned CLASS_POS_NORM = 6;
    localparam int unsigned CLASS_POS_INF  = 7;
    localparam int unsigned CLASS_SNAN     = 8;
    localparam int unsigned CLASS_QNAN     = 9;

    function automatic int unsigned exp_bits(input fp_format_e fmt);
        case (fmt)
            FP64:    return 11;
            FP16:    return 5;
            FP8:     return 5;
            FP16ALT: return 8;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned man_bits(input fp_format_e fmt);
        case (fmt)
            FP64:    return 52;
            FP16:    return 10;
            FP8:     return 2;
            FP16ALT: return 7;
            default: return 23;
        endcase
    endfunction

    function automatic int unsigned fp_width(input fp_format_e fmt);
        return 1 + exp_bits(fmt) + man_bits(fmt);
    endfunction

    // {0, exponent all ones, mantissa MSB set, rest zero}, right-aligned in MAX_WIDTH bits
    function automatic logic [MAX_WIDTH-1:0] canonical_qnan(input fp_format_e fmt);
        logic [MAX_WIDTH-1:0] pat;
        int unsigned e;
        int unsigned m;
        pat = '0;
        e   = exp_bits(fmt);
        m   = man_bits(fmt);
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if ((i >= m - 1) && (i < m + e)) begin
                pat[i] = 1'b1;
            end
        end
        return pat;
    endfunction

endpackage

// File: rtl/fpnew_class_encoder_if.sv
// Input/output handshake bundle of the class encoder.
interface fpnew_class_encoder_if
    import fpnew_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned FLEN      = 64,
    parameter int unsigned TAG_WIDTH = 4
);
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [WIDTH-1:0]     value_i;
    fp_info_t             info_i;
    class_mode_e          mode_i;
    logic [TAG_WIDTH-1:0] tag_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [FLEN-1:0]      result_o;
    logic                 nv_o;
    logic [TAG_WIDTH-1:0] tag_o;

    modport master (
        output in_valid_i, value_i, info_i, mode_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, nv_o, tag_o
    );

    modport slave (
        input  in_valid_i, value_i, info_i, mode_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, nv_o, tag_o
    );
endinterface

// File: rtl/fpnew_out_skid.sv
// Two-entry output buffer: an output register plus a skid register, so the
// ready towards the producer depends only on registered state.
module fpnew_out_skid
    import fpnew_pkg::*;
#(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);
    skid_state_e state_q, state_d;
    T            out_q, out_d;
    T            skid_q, skid_d;
    logic        accept;
    logic        pop;

    assign in_ready_o  = (state_q != SKID_TWO) && !rst_i;
    assign out_valid_o = (state_q != SKID_EMPTY);
    assign out_data_o  = out_q;
    assign accept      = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    // Next state and register loads; a flush drops the offered item and keeps data regs.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (accept) begin
                        out_d   = in_data_i;
                        state_d = SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (accept && pop) begin
                        out_d = in_data_i;
                    end else if (accept) begin
                        skid_d  = in_data_i;
                        state_d = SKID_TWO;
                    end else if (pop) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    if (pop) begin
                        out_d   = skid_q;
                        state_d = SKID_ONE;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    // State and payload registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SKID_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end
endmodule

// File: rtl/fpnew_class_encoder.sv
// FPU write-back encoder: FCLASS mask or canonicalised NaN-boxed result,
// registered through a two-entry output buffer.
module fpnew_class_encoder
    import fpnew_pkg::*;
#(
    parameter fp_format_e  FpFormat  = fp_format_e'(0),
    parameter int unsigned FLEN      = 64,
    parameter int unsigned TAG_WIDTH = 4
) (
    input logic                  clk_i,
    input logic                  rst_i,
    input logic                  flush_i,
    fpnew_class_encoder_if.slave bus
);
    localparam int unsigned          WIDTH      = fp_width(FpFormat);
    localparam logic [MAX_WIDTH-1:0] CANON_FULL = canonical_qnan(FpFormat);

    typedef struct packed {
        logic [FLEN-1:0]      result;
        logic                 nv;
        logic [TAG_WIDTH-1:0] tag;
    } payload_t;

    logic [NUM_CLASSES-1:0] mask;
    logic                   sign;
    payload_t               in_payload;
    payload_t               out_payload;

    // FCLASS one-hot; an unboxed operand reads as a quiet NaN.
    always_comb begin
        mask = '0;
        sign = bus.value_i[WIDTH-1];
        if (!bus.info_i.is_boxed) begin
            mask[CLASS_QNAN] = 1'b1;
        end else if (bus.info_i.is_nan && bus.info_i.is_signalling) begin
            mask[CLASS_SNAN] = 1'b1;
        end else if (bus.info_i.is_nan || bus.info_i.is_quiet) begin
            mask[CLASS_QNAN] = 1'b1;
        end else if (bus.info_i.is_inf) begin
            mask[sign ? CLASS_NEG_INF : CLASS_POS_INF] = 1'b1;
        end else if (bus.info_i.is_normal) begin
            mask[sign ? CLASS_NEG_NORM : CLASS_POS_NORM] = 1'b1;
        end else if (bus.info_i.is_subnormal) begin
            mask[sign ? CLASS_NEG_SUB : CLASS_POS_SUB] = 1'b1;
        end else if (bus.info_i.is_zero) begin
            mask[sign ? CLASS_NEG_ZERO : CLASS_POS_ZERO] = 1'b1;
        end else begin
            mask[CLASS_QNAN] = 1'b1;
        end
    end

    // Payload selection; the NaN box is built by presetting all ones.
    always_comb begin
        in_payload     = '0;
        in_payload.tag = bus.tag_i;
        if (bus.mode_i == CLASS_MASK) begin
            in_payload.result[NUM_CLASSES-1:0] = mask;
            in_payload.nv                      = 1'b0;
        end else begin
            in_payload.result = '1;
            in_payload.result[WIDTH-1:0] = bus.info_i.is_nan ? CANON_FULL[WIDTH-1:0]
                                                             : bus.value_i;
            in_payload.nv = bus.info_i.is_signalling;
        end
    end

    fpnew_out_skid #(
        .T (payload_t)
    ) i_out_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (bus.in_valid_i),
        .in_ready_o  (bus.in_ready_o),
        .in_data_i   (in_payload),
        .out_valid_o (bus.out_valid_o),
        .out_ready_i (bus.out_ready_i),
        .out_data_o  (out_payload)
    );

    assign bus.result_o = out_payload.result;
    assign bus.nv_o     = out_payload.nv;
    assign bus.tag_o    = out_payload.tag;
endmodule

// File: tb/tb_fpnew_class_encoder.sv
// Directed bench for fpnew_class_encoder, FP32 into FLEN 64.
module tb_fpnew_class_encoder;
    import fpnew_pkg::*;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    // info bit order: normal, subnormal, zero, inf, nan, signalling, quiet, boxed
    localparam logic [7:0] I_NORM    = 8'b1000_0001;
    localparam logic [7:0] I_SUB     = 8'b0100_0001;
    localparam logic [7:0] I_ZERO    = 8'b0010_0001;
    localparam logic [7:0] I_INF     = 8'b0001_0001;
    localparam logic [7:0] I_SNAN    = 8'b0000_1101;
    localparam logic [7:0] I_UNBOXED = 8'b1000_0000;

    fpnew_class_encoder_if #(.WIDTH(32), .FLEN(64), .TAG_WIDTH(4)) bus ();

    fpnew_class_encoder #(
        .FpFormat  (FP32),
        .FLEN      (64),
        .TAG_WIDTH (4)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Offer one item and advance to the next falling edge.
    task automatic push(input class_mode_e mode, input logic [31:0] value,
                        input logic [7:0] info, input logic [3:0] tag);
        bus.in_valid_i = 1'b1;
        bus.mode_i     = mode;
        bus.value_i    = value;
        bus.info_i     = fp_info_t'(info);
        bus.tag_i      = tag;
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        bus.in_valid_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.value_i     = '0;
        bus.info_i      = '0;
        bus.mode_i      = CLASS_MASK;
        bus.tag_i       = '0;
        bus.out_ready_i = 1'b1;

        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready_o),  64'd0);
        check("rst_result",    bus.result_o,         64'd0);
        check("rst_tag",       64'(bus.tag_o),       64'd0);
        check("rst_nv",        64'(bus.nv_o),        64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready_o), 64'd1);
        @(negedge clk);
        check("idle_out_valid", 64'(bus.out_valid_o), 64'd0);

        // Streaming, out_ready held high: one result per cycle
        push(CLASS_MASK, 32'hFF80_0000, I_INF, 4'd3);
        check("neg_inf_valid",  64'(bus.out_valid_o), 64'd1);
        check("neg_inf_mask",   bus.result_o, 64'h0000_0000_0000_0001);
        check("neg_inf_nv",     64'(bus.nv_o), 64'd0);
        check("neg_inf_tag",    64'(bus.tag_o), 64'd3);
        push(CANON_BOX, 32'h7F80_0001, I_SNAN, 4'd4);
        check("snan_canon",     bus.result_o, 64'hFFFF_FFFF_7FC0_0000);
        check("snan_nv",        64'(bus.nv_o), 64'd1);
        check("snan_tag",       64'(bus.tag_o), 64'd4);
        push(CANON_BOX, 32'h3F80_0000, I_NORM, 4'd5);
        check("one_box",        bus.result_o, 64'hFFFF_FFFF_3F80_0000);
        check("one_box_nv",     64'(bus.nv_o), 64'd0);
        push(CLASS_MASK, 32'h3F80_0000, I_NORM, 4'd6);
        check("pos_norm_mask",  bus.result_o, 64'h40);
        check("pos_norm_tag",   64'(bus.tag_o), 64'd6);
        push(CLASS_MASK, 32'h8000_0001, I_SUB, 4'd7);
        check("neg_sub_mask",   bus.result_o, 64'h4);
        push(CLASS_MASK, 32'h0000_0000, I_ZERO, 4'd8);
        check("pos_zero_mask",  bus.result_o, 64'h10);
        push(CLASS_MASK, 32'h8000_0000, I_ZERO, 4'd9);
        check("neg_zero_mask",  bus.result_o, 64'h8);
        push(CLASS_MASK, 32'h3F80_0000, I_UNBOXED, 4'd10);
        check("unboxed_mask",   bus.result_o, 64'h200);
        push(CLASS_MASK, 32'hFF80_0001, I_SNAN, 4'd11);
        check("snan_mask",      bus.result_o, 64'h100);
        check("snan_mask_nv",   64'(bus.nv_o), 64'd0);
        push(CLASS_MASK, 32'h7F80_0000, I_INF, 4'd12);
        check("pos_inf_mask",   bus.result_o, 64'h80);
        push(CANON_BOX, 32'hC000_0000, I_NORM, 4'd13);
        check("neg_box",        bus.result_o, 64'hFFFF_FFFF_C000_0000);
        check("stream_valid",   64'(bus.out_valid_o), 64'd1);
        idle_cycle();
        check("drain_valid",    64'(bus.out_valid_o), 64'd0);

        // Backpressure: fill both entries, then release
        bus.out_ready_i = 1'b0;
        push(CANON_BOX, 32'h4000_0000, I_NORM, 4'd1);
        check("bp_first_tag",   64'(bus.tag_o), 64'd1);
        check("bp_one_ready",   64'(bus.in_ready_o), 64'd1);
        push(CANON_BOX, 32'h4040_0000, I_NORM, 4'd2);
        check("bp_full_ready",  64'(bus.in_ready_o), 64'd0);
        check("bp_hold_tag",    64'(bus.tag_o), 64'd1);
        check("bp_hold_result", bus.result_o, 64'hFFFF_FFFF_4000_0000);
        idle_cycle();
        check("bp_stall_tag",   64'(bus.tag_o), 64'd1);
        check("bp_stall_res",   bus.result_o, 64'hFFFF_FFFF_4000_0000);
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        check("bp_second_tag",  64'(bus.tag_o), 64'd2);
        check("bp_second_res",  bus.result_o, 64'hFFFF_FFFF_4040_0000);
        check("bp_second_vld",  64'(bus.out_valid_o), 64'd1);
        check("bp_ready_back",  64'(bus.in_ready_o), 64'd1);
        @(negedge clk);
        check("bp_drained",     64'(bus.out_valid_o), 64'd0);

        // Reset while holding two items
        bus.out_ready_i = 1'b0;
        push(CANON_BOX, 32'h4000_0000, I_NORM, 4'd6);
        push(CANON_BOX, 32'h4040_0000, I_NORM, 4'd7);
        check("two_ready",      64'(bus.in_ready_o), 64'd0);
        bus.in_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_ready",  64'(bus.in_ready_o), 64'd0);
        @(negedge clk);
        check("mrst_valid",     64'(bus.out_valid_o), 64'd0);
        check("mrst_result",    bus.result_o, 64'd0);
        check("mrst_tag",       64'(bus.tag_o), 64'd0);
        check("mrst_ready",     64'(bus.in_ready_o), 64'd0);
        rst = 1'b0;
        #1;
        check("mrst_ready_up",  64'(bus.in_ready_o), 64'd1);
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        check("mrst_no_item",   64'(bus.out_valid_o), 64'd0);

        // Flush while in ONE with a new item offered
        bus.out_ready_i = 1'b0;
        push(CLASS_MASK, 32'h3F80_0000, I_NORM, 4'd8);
        check("fl_one_valid",   64'(bus.out_valid_o), 64'd1);
        flush = 1'b1;
        push(CLASS_MASK, 32'hFF80_0000, I_INF, 4'd9);
        check("fl_valid",       64'(bus.out_valid_o), 64'd0);
        flush = 1'b0;
        bus.out_ready_i = 1'b1;
        idle_cycle();
        check("fl_dropped_1",   64'(bus.out_valid_o), 64'd0);
        idle_cycle();
        check("fl_dropped_2",   64'(bus.out_valid_o), 64'd0);
        push(CLASS_MASK, 32'h0000_0001, I_SUB, 4'd10);
        check("fl_after_tag",   64'(bus.tag_o), 64'd10);
        check("fl_after_mask",  bus.result_o, 64'h20);
        idle_cycle();
        check("fl_after_empty", 64'(bus.out_valid_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
